// File: rtl/opregister_pkg.sv
// Shared types for the operation register file: opcodes, FSM states, opcode width.
package opregister_pkg;

   localparam int unsigned OP_W = 3;

   typedef enum logic [OP_W-1:0] {
      OP_PASS = 3'b000,
      OP_INV  = 3'b001,
      OP_INC  = 3'b010,
      OP_DEC  = 3'b011,
      OP_SHL  = 3'b100,
      OP_SHR  = 3'b101,
      OP_ROTL = 3'b110,
      OP_ROTR = 3'b111
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   // Opcodes 1xx are the shift/rotate family.
   function automatic logic is_shift(input op_e op);
      return op[2];
   endfunction

endpackage

// File: rtl/opregister_alu.sv
// Combinational single step of an operation: unary ops ignore the amount,
// shifts/rotates move by i_amount bits and report the last bit moved out.
module opregister_alu
   import opregister_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   localparam int unsigned SW = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] i_value,
   input  op_e              i_op,
   input  logic [SW-1:0]    i_amount,
   output logic [WIDTH-1:0] o_result_c,
   output logic             o_carry_c
);

   logic [WIDTH:0]     ext_l;
   logic [WIDTH:0]     ext_r;
   logic [2*WIDTH-1:0] dbl_l;
   logic [2*WIDTH-1:0] dbl_r;
   logic               amt_nz;

   always_comb begin
      // Extra guard bit catches the last bit shifted out; doubled copy gives rotation.
      ext_l  = {1'b0, i_value} << i_amount;
      ext_r  = {i_value, 1'b0} >> i_amount;
      dbl_l  = {i_value, i_value} << i_amount;
      dbl_r  = {i_value, i_value} >> i_amount;
      amt_nz = (i_amount != '0);
      o_result_c = i_value;
      o_carry_c  = 1'b0;
      case (i_op)
         OP_PASS: o_result_c = i_value;
         OP_INV:  o_result_c = ~i_value;
         OP_INC:  {o_carry_c, o_result_c} = {1'b0, i_value} + (WIDTH+1)'(1);
         OP_DEC: begin
            o_result_c = i_value - WIDTH'(1);
            o_carry_c  = (i_value == '0);
         end
         OP_SHL: begin
            o_result_c = ext_l[WIDTH-1:0];
            o_carry_c  = ext_l[WIDTH];
         end
         OP_SHR: begin
            o_result_c = ext_r[WIDTH:1];
            o_carry_c  = ext_r[0];
         end
         OP_ROTL: begin
            o_result_c = dbl_l[2*WIDTH-1:WIDTH];
            o_carry_c  = amt_nz & dbl_l[WIDTH];
         end
         OP_ROTR: begin
            o_result_c = dbl_r[WIDTH-1:0];
            o_carry_c  = amt_nz & dbl_r[WIDTH-1];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/opregister_file.sv
// Bank of DEPTH operation registers with registered read port and in-place
// read-modify-write ops. Define OPREGISTER_FILE_BARREL_EN for single-step shifts.
module opregister_file
   import opregister_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH),
   localparam int unsigned SW = $clog2(WIDTH)
) (
   input  logic             i_w_clk,
   input  logic             i_w_reset,
   input  logic [AW-1:0]    i_w_addr,
   input  logic [WIDTH-1:0] i_w_data,
   input  logic             i_w_we,
   input  logic             i_w_oe,
   input  logic             i_w_start,
   input  logic [OP_W-1:0]  i_w_opsel,
   input  logic [SW-1:0]    i_w_amount,
   output logic [WIDTH-1:0] o_w_out,
   output logic             o_w_valid,
   output logic             o_w_busy,
   output logic             o_w_done,
   output logic             o_w_zero,
   output logic             o_w_carry
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] regs_q [DEPTH];
   logic [WIDTH-1:0] regs_d [DEPTH];
   logic [WIDTH-1:0] work_q, work_d;
   op_e              op_q, op_d;
   logic [SW-1:0]    amt_q, amt_d;
   logic [AW-1:0]    tgt_q, tgt_d;
   logic [WIDTH-1:0] out_q, out_d;
   logic             valid_q, valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             zero_q, zero_d;
   logic             carry_q, carry_d;

   logic             addr_ok_c;
   logic [SW-1:0]    step_amt_c;
   logic [WIDTH-1:0] alu_res_c;
   logic             alu_carry_c;
   logic [WIDTH-1:0] wb_res_c;
   logic             wb_carry_c;

   // Only a non-power-of-two depth can be addressed out of range.
   if (DEPTH == (1 << AW)) begin : g_full_depth
      assign addr_ok_c = 1'b1;
   end else begin : g_part_depth
      assign addr_ok_c = (32'(i_w_addr) < DEPTH);
   end

   opregister_alu #(.WIDTH(WIDTH)) u_alu (
      .i_value    (work_q),
      .i_op       (op_q),
      .i_amount   (step_amt_c),
      .o_result_c (alu_res_c),
      .o_carry_c  (alu_carry_c)
   );

`ifdef OPREGISTER_FILE_BARREL_EN
   always_comb begin
      step_amt_c = amt_q;
      wb_res_c   = alu_res_c;
      wb_carry_c = alu_carry_c;
   end
`else
   logic [SW-1:0] cnt_q, cnt_d;
   logic          wc_q, wc_d;
   logic          apply_c;

   // Iterative shifts already hold their result; unary ops and zero-distance shifts apply in DONE.
   always_comb begin
      apply_c    = !is_shift(op_q) || (amt_q == '0);
      step_amt_c = (state_q == ST_RUN) ? SW'(1) : amt_q;
      wb_res_c   = apply_c ? alu_res_c : work_q;
      wb_carry_c = apply_c ? alu_carry_c : wc_q;
   end
`endif

   always_comb begin
      state_d = state_q;
      regs_d  = regs_q;
      work_d  = work_q;
      op_d    = op_q;
      amt_d   = amt_q;
      tgt_d   = tgt_q;
      out_d   = out_q;
      valid_d = 1'b0;
      done_d  = 1'b0;
      zero_d  = zero_q;
      carry_d = carry_q;
`ifndef OPREGISTER_FILE_BARREL_EN
      cnt_d   = cnt_q;
      wc_d    = wc_q;
`endif

      if (i_w_oe) begin
         valid_d = 1'b1;
         out_d   = addr_ok_c ? regs_q[i_w_addr] : '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (i_w_we) begin
               if (addr_ok_c) regs_d[i_w_addr] = i_w_data;
            end else if (i_w_start && addr_ok_c) begin
               op_d    = op_e'(i_w_opsel);
               amt_d   = i_w_amount;
               tgt_d   = i_w_addr;
               work_d  = regs_q[i_w_addr];
               state_d = ST_DONE;
`ifndef OPREGISTER_FILE_BARREL_EN
               cnt_d   = i_w_amount;
               wc_d    = 1'b0;
               if (is_shift(op_e'(i_w_opsel)) && (i_w_amount != '0)) state_d = ST_RUN;
`endif
            end
         end
         ST_RUN: begin
`ifndef OPREGISTER_FILE_BARREL_EN
            work_d = alu_res_c;
            wc_d   = alu_carry_c;
            cnt_d  = cnt_q - SW'(1);
            if (cnt_q == SW'(1)) state_d = ST_DONE;
`else
            state_d = ST_DONE;
`endif
         end
         ST_DONE: begin
            regs_d[tgt_q] = wb_res_c;
            zero_d        = (wb_res_c == '0);
            carry_d       = wb_carry_c;
            done_d        = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge i_w_clk or negedge i_w_reset) begin
      if (!i_w_reset) begin
         state_q <= ST_IDLE;
         regs_q  <= '{default: '0};
         work_q  <= '0;
         op_q    <= OP_PASS;
         amt_q   <= '0;
         tgt_q   <= '0;
         out_q   <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         state_q <= state_d;
         regs_q  <= regs_d;
         work_q  <= work_d;
         op_q    <= op_d;
         amt_q   <= amt_d;
         tgt_q   <= tgt_d;
         out_q   <= out_d;
         valid_q <= valid_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         zero_q  <= zero_d;
         carry_q <= carry_d;
      end
   end

`ifndef OPREGISTER_FILE_BARREL_EN
   always_ff @(posedge i_w_clk or negedge i_w_reset) begin
      if (!i_w_reset) begin
         cnt_q <= '0;
         wc_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         wc_q  <= wc_d;
      end
   end
`endif

   assign o_w_out   = out_q;
   assign o_w_valid = valid_q;
   assign o_w_busy  = busy_q;
   assign o_w_done  = done_q;
   assign o_w_zero  = zero_q;
   assign o_w_carry = carry_q;

endmodule

// File: tb/tb_opregister_file.sv
// Scoreboard bench for opregister_file: reads and op flags are queued on issue
// and checked when valid/done appear.
module tb_opregister_file;
   import opregister_pkg::*;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] addr = '0;
   logic [7:0] data = '0;
   logic       we = 1'b0;
   logic       oe = 1'b0;
   logic       start = 1'b0;
   logic [2:0] opsel = '0;
   logic [2:0] amount = '0;
   logic [7:0] out;
   logic       valid, busy, done, zero, carry;

   int checks = 0;
   int failures = 0;

   logic [7:0] mem [DEPTH];
   logic [7:0] rd_q [$];
   logic [1:0] flag_q [$];

   opregister_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .i_w_clk    (clk),
      .i_w_reset  (rst_n),
      .i_w_addr   (addr),
      .i_w_data   (data),
      .i_w_we     (we),
      .i_w_oe     (oe),
      .i_w_start  (start),
      .i_w_opsel  (opsel),
      .i_w_amount (amount),
      .o_w_out    (out),
      .o_w_valid  (valid),
      .o_w_busy   (busy),
      .o_w_done   (done),
      .o_w_zero   (zero),
      .o_w_carry  (carry)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // Bit-at-a-time reference model.
   task automatic model(input logic [7:0] v, input logic [2:0] op, input int n,
                        output logic [7:0] r, output logic c);
      r = v;
      c = 1'b0;
      case (op)
         3'd1: r = ~v;
         3'd2: begin r = v + 8'd1; c = (v == 8'hFF); end
         3'd3: begin r = v - 8'd1; c = (v == 8'h00); end
         3'd4: repeat (n) begin c = r[7]; r = {r[6:0], 1'b0}; end
         3'd5: repeat (n) begin c = r[0]; r = {1'b0, r[7:1]}; end
         3'd6: repeat (n) begin c = r[7]; r = {r[6:0], r[7]}; end
         3'd7: repeat (n) begin c = r[0]; r = {r[0], r[7:1]}; end
         default: ;
      endcase
   endtask

   always @(posedge clk) begin
      #1;
      if (valid) begin
         if (rd_q.size() == 0) check("spurious_valid", 32'(valid), 32'd0);
         else check("rd_data", 32'(out), 32'(rd_q.pop_front()));
      end
      if (done) begin
         if (flag_q.size() == 0) check("spurious_done", 32'(done), 32'd0);
         else check("flags_cz", 32'({carry, zero}), 32'(flag_q.pop_front()));
      end
   end

   task automatic do_write(input logic [1:0] a, input logic [7:0] d);
      @(negedge clk);
      we = 1'b1; oe = 1'b0; start = 1'b0; addr = a; data = d;
      mem[a] = d;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic do_read(input logic [1:0] a);
      @(negedge clk);
      oe = 1'b1; we = 1'b0; start = 1'b0; addr = a;
      rd_q.push_back(mem[a]);
      @(negedge clk);
      oe = 1'b0;
      @(posedge clk); #1;
      check("valid_one_cycle", 32'(valid), 32'd0);
   endtask

   task automatic do_op(input logic [1:0] a, input logic [2:0] op, input int n, input bit poke);
      logic [7:0] r;
      logic       c;
      int         lat;
      bit         seen;
      model(mem[a], op, n, r, c);
      flag_q.push_back({c, (r == 8'h00)});
`ifdef OPREGISTER_FILE_BARREL_EN
      lat = 1;
`else
      lat = (op[2] && n > 0) ? n + 1 : 1;
`endif
      @(negedge clk);
      we = 1'b0; oe = 1'b0; start = 1'b1; addr = a; opsel = op; amount = 3'(n);
      @(posedge clk); #1;
      seen = 1'b0;
      for (int k = 1; k <= 20 && !seen; k++) begin
         @(negedge clk);
         start = 1'b0; we = 1'b0; oe = 1'b0;
         // Start, write and read aimed at the busy target.
         if (poke && k == 1) begin
            start = 1'b1; we = 1'b1; data = 8'h55; oe = 1'b1; opsel = 3'd0;
            rd_q.push_back(mem[a]);
         end
         @(posedge clk); #1;
         if (done) begin
            seen = 1'b1;
            check("latency", 32'(k), 32'(lat));
            check("busy_at_done", 32'(busy), 32'd0);
         end else begin
            check("busy", 32'(busy), 32'd1);
         end
      end
      if (!seen) check("done_timeout", 32'(done), 32'd1);
      mem[a] = r;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      logic [1:0] a;
      logic [2:0] op;
      int         n;

      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rst_out", 32'(out), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_zero", 32'(zero), 32'd0);
      check("rst_carry", 32'(carry), 32'd0);
      do_read(2'd2);

      do_write(2'd1, 8'h2D);
      do_read(2'd1);

      do_write(2'd3, 8'hFF);
      do_op(2'd3, OP_INC, 0, 1'b0);
      do_op(2'd3, OP_DEC, 0, 1'b0);
      do_read(2'd3);

      do_op(2'd1, OP_SHL, 3, 1'b1);
      do_read(2'd1);
      check("collision_model", 32'(mem[1]), 32'h68);

      do_write(2'd0, 8'h81);
      do_op(2'd0, OP_ROTL, 3, 1'b0);
      do_read(2'd0);

      // Back-to-back ops, plus a zero-distance rotate.
      do_write(2'd2, 8'hA6);
      do_op(2'd2, OP_SHR, 1, 1'b0);
      do_op(2'd2, OP_ROTR, 7, 1'b0);
      do_op(2'd2, OP_ROTR, 0, 1'b0);
      do_op(2'd2, OP_INV, 0, 1'b0);
      do_op(2'd2, OP_PASS, 0, 1'b0);
      do_read(2'd2);

      // Write and start together: write wins, no op runs.
      @(negedge clk);
      we = 1'b1; start = 1'b1; addr = 2'd2; data = 8'h11; opsel = OP_INV;
      mem[2] = 8'h11;
      @(negedge clk);
      we = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      check("dropped_start_busy", 32'(busy), 32'd0);
      do_read(2'd2);

      for (int i = 0; i < 8; i++) begin
         v  = 8'($urandom);
         a  = 2'($urandom_range(0, 3));
         op = 3'($urandom_range(0, 7));
         n  = int'($urandom_range(0, 7));
         do_write(a, v);
         do_op(a, op, n, 1'b0);
         do_read(a);
      end

      // Reset in the middle of a shift.
      do_write(2'd1, 8'h2D);
      @(negedge clk);
      start = 1'b1; addr = 2'd1; opsel = OP_SHL; amount = 3'd3;
      @(posedge clk); #1;
`ifndef OPREGISTER_FILE_BARREL_EN
      @(negedge clk);
      start = 1'b0;
      @(posedge clk); #1;
`endif
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("mid_rst_out", 32'(out), 32'd0);
      check("mid_rst_valid", 32'(valid), 32'd0);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_done", 32'(done), 32'd0);
      check("mid_rst_zero", 32'(zero), 32'd0);
      check("mid_rst_carry", 32'(carry), 32'd0);
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("post_rst_busy", 32'(busy), 32'd0);
      do_read(2'd1);

      repeat (4) @(negedge clk);
      check("rd_queue_empty", 32'(rd_q.size()), 32'd0);
      check("flag_queue_empty", 32'(flag_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
